// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// State encoding, requester select and default memory depth.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } sel_t;

    localparam int DEPTH_WORDS_DEF = 512;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; ptr remembers the side granted last.
// Bit 0 of req/grant is the fetch side, bit 1 the data side.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int RESET_PTR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    sel_t ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11)
                grant = (ptr == SEL_D) ? 2'b01 : 2'b10;
            else
                grant = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= (RESET_PTR != 0) ? SEL_D : SEL_I;
        else if (|grant)
            ptr <= grant[1] ? SEL_D : SEL_I;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle memory between a fetch port and a load/store
// port; every granted access runs IDLE -> ACCESS -> DONE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int RESET_PTR   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iReq,
    input  logic [31:0] iAdr,
    output logic        iAck,
    output logic        iErr,
    output logic [31:0] iRdata,
    input  logic        dReq,
    input  logic [31:0] dAdr,
    input  logic [31:0] dWdata,
    input  logic        dWe,
    output logic        dAck,
    output logic        dErr,
    output logic [31:0] dRdata,
    output logic [31:0] memAdr,
    output logic [31:0] writeData,
    output logic        memWrite,
    input  logic [31:0] readData,
    output logic        busy
);

    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    state_t      state;
    state_t      stateNext;
    sel_t        sel;
    logic [31:0] adrReg;
    logic [31:0] wdataReg;
    logic        weReg;
    logic        errReg;
    logic [1:0]  grant;
    logic        legal;

    rr_arb2 #(
        .RESET_PTR(RESET_PTR)
    ) uArb (
        .clk  (clk),
        .rst  (rst),
        .en   (state == IDLE && !rst),
        .req  ({dReq, iReq}),
        .grant(grant)
    );

    assign legal = (adrReg[1:0] == 2'b00) &&
                   ({2'b00, adrReg[31:2]} < DEPTH);

    always_ff @(posedge clk) begin
        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        memAdr    = '0;
        writeData = '0;
        memWrite  = 1'b0;
        unique case (state)
            IDLE:    if (|grant) stateNext = ACCESS;
            ACCESS: begin
                stateNext = DONE;
                if (legal) begin
                    memAdr    = adrReg;
                    writeData = wdataReg;
                    memWrite  = weReg && !rst;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (rst)
            stateNext = IDLE;
    end

    assign busy = (state != IDLE);
    assign iAck = (state == DONE) && (sel == SEL_I) && !rst;
    assign dAck = (state == DONE) && (sel == SEL_D) && !rst;
    assign iErr = iAck && errReg;
    assign dErr = dAck && errReg;

    // Request fields are copied at grant so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= SEL_I;
            adrReg   <= '0;
            wdataReg <= '0;
            weReg    <= 1'b0;
            errReg   <= 1'b0;
            iRdata   <= '0;
            dRdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        sel      <= grant[1] ? SEL_D : SEL_I;
                        adrReg   <= grant[1] ? dAdr : iAdr;
                        wdataReg <= grant[1] ? dWdata : '0;
                        weReg    <= grant[1] && dWe;
                    end
                end
                ACCESS: begin
                    errReg <= !legal;
                    if (legal && !weReg) begin
                        if (sel == SEL_D)
                            dRdata <= readData;
                        else
                            iRdata <= readData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory model.
// Vector table for lone accesses, hand sequences for arbitration and reset.
module tb_mem_port_arbiter;

    localparam int DW = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        iReq;
    logic [31:0] iAdr;
    logic        iAck;
    logic        iErr;
    logic [31:0] iRdata;
    logic        dReq;
    logic [31:0] dAdr;
    logic [31:0] dWdata;
    logic        dWe;
    logic        dAck;
    logic        dErr;
    logic [31:0] dRdata;
    logic [31:0] memAdr;
    logic [31:0] writeData;
    logic        memWrite;
    logic [31:0] readData;
    logic        busy;

    logic [31:0] mem [DW];
    int          writes = 0;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    assign readData = mem[memAdr[10:2]];

    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAdr[10:2]] = writeData;
            writes = writes + 1;
        end
    end

    mem_port_arbiter #(
        .DEPTH_WORDS(DW),
        .RESET_PTR  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iAdr     (iAdr),
        .iAck     (iAck),
        .iErr     (iErr),
        .iRdata   (iRdata),
        .dReq     (dReq),
        .dAdr     (dAdr),
        .dWdata   (dWdata),
        .dWe      (dWe),
        .dAck     (dAck),
        .dErr     (dErr),
        .dRdata   (dRdata),
        .memAdr   (memAdr),
        .writeData(writeData),
        .memWrite (memWrite),
        .readData (readData),
        .busy     (busy)
    );

    typedef struct {
        string       name;
        logic        isD;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        expErr;
        logic [31:0] expRdata;
        int          expWrites;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chkS(input string nm, input string act, input string exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got '%s', expected '%s'", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; returns ack latency in cycles (-1 = none).
    task automatic runOne(input logic isD, input logic we,
                          input logic [31:0] adr, input logic [31:0] wdata,
                          output int lat, output logic err,
                          output logic [31:0] rd);
        lat = -1;
        err = 1'b0;
        rd  = '0;
        if (isD) begin
            dReq = 1'b1; dAdr = adr; dWdata = wdata; dWe = we;
        end else begin
            iReq = 1'b1; iAdr = adr;
        end
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) begin
                iAdr = ~adr; dAdr = ~adr; dWdata = ~wdata; dWe = ~we;
            end
            if (isD ? dAck : iAck) begin
                lat = c;
                err = isD ? dErr : iErr;
                rd  = isD ? dRdata : iRdata;
                break;
            end
        end
        iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
        cyc();
    endtask

    vec_t        vecs[11];
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          w0;
    int          iAt;
    int          dAt;
    logic [31:0] rdI;
    logic        errD;
    string       seq;
    int          nAck;

    initial begin
        for (int i = 0; i < DW; i++) mem[i] = '0;
        mem[4]   = 32'hDEADBEEF;
        mem[511] = 32'hCAFEF00D;

        vecs[0]  = '{"fetch10",   1'b0, 1'b0, 32'h10,   32'h0,
                     1'b0, 32'hDEADBEEF, 0};
        vecs[1]  = '{"store24",   1'b1, 1'b1, 32'h24,   32'hA5A50001,
                     1'b0, 32'h12345678, 1};
        vecs[2]  = '{"load24",    1'b1, 1'b0, 32'h24,   32'h0,
                     1'b0, 32'hA5A50001, 0};
        vecs[3]  = '{"store22",   1'b1, 1'b1, 32'h22,   32'hFFFFFFFF,
                     1'b1, 32'hA5A50001, 0};
        vecs[4]  = '{"load20",    1'b1, 1'b0, 32'h20,   32'h0,
                     1'b0, 32'h12345678, 0};
        vecs[5]  = '{"load800",   1'b1, 1'b0, 32'h800,  32'h0,
                     1'b1, 32'h12345678, 0};
        vecs[6]  = '{"fetch7fc",  1'b0, 1'b0, 32'h7FC,  32'h0,
                     1'b0, 32'hCAFEF00D, 0};
        vecs[7]  = '{"fetch11",   1'b0, 1'b0, 32'h11,   32'h0,
                     1'b1, 32'hCAFEF00D, 0};
        vecs[8]  = '{"store7fc",  1'b1, 1'b1, 32'h7FC,  32'h0BADC0DE,
                     1'b0, 32'h12345678, 1};
        vecs[9]  = '{"fetch7fc2", 1'b0, 1'b0, 32'h7FC,  32'h0,
                     1'b0, 32'h0BADC0DE, 0};
        vecs[10] = '{"store1000", 1'b1, 1'b1, 32'h1000, 32'h1,
                     1'b1, 32'h12345678, 0};

        rst = 1'b1;
        iReq = 1'b0; iAdr = '0;
        dReq = 1'b0; dAdr = '0; dWdata = '0; dWe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_iAck",     32'(iAck),     32'd0);
        chk("rst_dAck",     32'(dAck),     32'd0);
        chk("rst_memWrite", 32'(memWrite), 32'd0);
        chk("rst_memAdr",   memAdr,        32'h0);
        chk("rst_iRdata",   iRdata,        32'h0);
        chk("rst_dRdata",   dRdata,        32'h0);

        // Both sides at once after reset: fetch first, store second.
        iReq = 1'b1; iAdr = 32'h10;
        dReq = 1'b1; dAdr = 32'h20; dWdata = 32'h12345678; dWe = 1'b1;
        iAt = -1; dAt = -1; rdI = '0; errD = 1'b1; w0 = writes;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (iAck && iAt < 0) begin
                iAt = c; rdI = iRdata; iReq = 1'b0;
            end
            if (dAck && dAt < 0) begin
                dAt = c; errD = dErr; dReq = 1'b0; dWe = 1'b0;
            end
            if (iAt >= 0 && dAt >= 0) break;
        end
        cyc();
        chk("both_iAckCycle", 32'(iAt), 32'd2);
        chk("both_dAckCycle", 32'(dAt), 32'd5);
        chk("both_iRdata",    rdI,      32'hDEADBEEF);
        chk("both_dErr",      32'(errD), 32'd0);
        chk("both_writes",    32'(writes - w0), 32'd1);
        chk("both_mem8",      mem[8],   32'h12345678);

        // Both held for 12 cycles: acks must alternate three cycles apart.
        iReq = 1'b1; iAdr = 32'h10;
        dReq = 1'b1; dAdr = 32'h20; dWe = 1'b0;
        seq = ""; nAck = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (iAck) seq = {seq, $sformatf("I%0d ", c)};
            if (dAck) seq = {seq, $sformatf("D%0d ", c)};
        end
        iReq = 1'b0; dReq = 1'b0;
        cyc();
        chkS("alt_sequence", seq, "I2 D5 I8 D11 ");
        chk("alt_busy",   32'(busy), 32'd0);
        chk("alt_iRdata", iRdata,    32'hDEADBEEF);
        chk("alt_dRdata", dRdata,    32'h12345678);

        for (int v = 0; v < 11; v++) begin
            w0 = writes;
            runOne(vecs[v].isD, vecs[v].we, vecs[v].adr, vecs[v].wdata,
                   lat, err, rd);
            chk({vecs[v].name, "_lat"},    32'(lat), 32'd2);
            chk({vecs[v].name, "_err"},    32'(err), 32'(vecs[v].expErr));
            chk({vecs[v].name, "_rdata"},  rd,       vecs[v].expRdata);
            chk({vecs[v].name, "_writes"}, 32'(writes - w0),
                32'(vecs[v].expWrites));
            chk({vecs[v].name, "_idleAdr"}, memAdr,  32'h0);
        end
        chk("mem8_after_illegal", mem[8],   32'h12345678);
        chk("mem511_store",       mem[511], 32'h0BADC0DE);

        // Reset lands on the ACCESS cycle of a store.
        w0 = writes;
        dReq = 1'b1; dAdr = 32'h40; dWdata = 32'h55555555; dWe = 1'b1;
        cyc();
        chk("abort_busy",       32'(busy),     32'd1);
        chk("abort_memWrite",   32'(memWrite), 32'd1);
        rst = 1'b1;
        dReq = 1'b0; dWe = 1'b0;
        #1;
        chk("abort_memWriteRst", 32'(memWrite), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("abort_busyAfter", 32'(busy),   32'd0);
        chk("abort_dRdata",    dRdata,      32'h0);
        nAck = 0;
        for (int c = 0; c < 5; c++) begin
            if (dAck || iAck) nAck++;
            cyc();
        end
        chk("abort_noAck",  32'(nAck),          32'd0);
        chk("abort_mem16",  mem[16],            32'h0);
        chk("abort_writes", 32'(writes - w0),   32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DEPTH_WORDS, default 512: number of 32-bit words in the shared instruction/data memory.
REQ-002 Parameter RESET_PTR, default 1: initial round-robin pointer, where 1 = data granted last.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 iReq  input  1  fetch request; held high until iAck.
REQ-006 iAdr  input  32  fetch byte address.
REQ-007 iAck  output  1  one-cycle fetch completion pulse.
REQ-008 iErr  output  1  valid with iAck; 1 = misaligned or out-of-range address.
REQ-009 iRdata  output  32  fetched word, registered; valid with iAck and held until the next fetch iAck.
REQ-010 dReq  input  1  load/store request; held high until dAck.
REQ-011 dAdr  input  32  load/store byte address.
REQ-012 dWdata  input  32  store data.
REQ-013 dWe  input  1  1 = store, 0 = load.
REQ-014 dAck, dErr, dRdata  output  1/1/32  data-side equivalents of iAck, iErr and iRdata.
REQ-015 memAdr  output  32  memory byte address.
REQ-016 writeData  output  32  memory write data.
REQ-017 memWrite  output  1  memory write enable; memory writes on the clk edge.
REQ-018 readData  input  32  memory read word; combinational from memAdr.
REQ-019 busy  output  1  high in every non-IDLE state.

Function
REQ-020 FSM states are IDLE, ACCESS and DONE; each granted access takes exactly 3 cycles (IDLE->ACCESS->DONE->IDLE).
REQ-021 IDLE, no request pending: stay in IDLE with memWrite=0.
REQ-022 IDLE, exactly one request pending: grant it and latch its adr, wdata and we (we forced to 0 for fetch) into internal registers; next state ACCESS.
REQ-023 IDLE, both requests pending: grant the requester not granted last (round-robin), then update the pointer.
REQ-024 ACCESS, legal address: memAdr and writeData come from the latched registers, and memWrite equals the latched we.
REQ-025 ACCESS, legal load or fetch: capture readData into the granted requester's rdata register at the end of the cycle.
REQ-026 ACCESS, illegal address: memWrite=0, the rdata register is unchanged, and err is set.
REQ-027 An address is illegal when adr[1:0]!=0 or (adr>>2) >= DEPTH_WORDS.
REQ-028 DONE: pulse the granted requester's ack for exactly one cycle, with err valid; next state IDLE.
REQ-029 Requests are never sampled in DONE or ACCESS; a requester whose req is still high in the IDLE after its ack is served again as a new request.
REQ-030 memAdr shall be 0 in IDLE and DONE; memWrite shall be 1 only in ACCESS with a legal store.
REQ-031 A change of req, adr, wdata or we after the grant has no effect on the access in flight.
REQ-032 There shall be no combinational path from any request input to any output.
REQ-033 The non-granted requester shall wait at most one full access (3 cycles) when the other side requests continuously.

Reset
REQ-034 While rst is high: next state IDLE, pointer = RESET_PTR, all acks and errs = 0, rdata registers = 0.
REQ-035 memWrite shall be forced to 0 in any cycle where rst is high, including an ACCESS cycle, so no store completes.
REQ-036 An access aborted by reset shall produce no ack.

Structure
REQ-037 A shared package mem_arb_pkg holds the state enum, the I/D requester select encoding and the DEPTH_WORDS default.
REQ-038 The grant decision is a sub-module rr_arb2: two request inputs, a pointer register, and a one-hot grant output, with the pointer updated only on grant.

Verification
REQ-039 Lone fetch: iAdr=0x10, mem[4]=0xDEADBEEF -> iAck at cycle 3 with iRdata=0xDEADBEEF and iErr=0; memWrite stays 0 throughout.
REQ-040 Simultaneous iReq and dReq (store 0x20 <- 0x12345678) after reset -> fetch served first with iAck at cycle 3; store then completes with dAck at cycle 6; a later load of 0x20 returns 0x12345678.
REQ-041 Continuous iReq and dReq for 12 cycles -> acks alternate I, D, I, D, each 3 cycles apart.
REQ-042 Illegal addresses: store to 0x22 -> dAck with dErr=1, memWrite never 1, memory unchanged; load from 0x800 -> dAck with dErr=1 and dRdata unchanged.
REQ-043 rst asserted during the ACCESS cycle of a store to 0x40 -> mem[16] unchanged, no dAck, busy=0 on the next cycle.
